// File: rtl/antialias_sched.sv
// Alias-reduction sequencer: fills one 576-line granule, then issues butterfly pairs.
// Optional sticky protocol checker enabled by defining ANTIALIAS_SCHED_ERR_EN.
module antialias_sched #(
    parameter int N_LINES = 576,
    parameter int SB_LEN  = 18,
    parameter int N_BFLY  = 8,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              granule_start,
    input  logic              window_switching_flag_in,
    input  logic [1:0]        block_type_in,
    input  logic              mixed_block_flag_in,
    input  logic              din_v,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              pair_v,
    input  logic              pair_ready,
    output logic [ADDR_W-1:0] rd_addr_x,
    output logic [ADDR_W-1:0] rd_addr_y,
    output logic [2:0]        coef_idx,
    output logic              busy,
    output logic              granule_done,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_BFLY,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(N_LINES - 1);
    localparam logic [ADDR_W-1:0] SB_STEP   = ADDR_W'(SB_LEN);
    localparam logic [2:0]        LAST_I    = 3'(N_BFLY - 1);
    localparam logic [4:0]        SB_MAX    = 5'(N_LINES / SB_LEN - 1);

    state_t            r_state;
    logic              r_ws;
    logic [1:0]        r_bt;
    logic              r_mixed;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_rd_x;
    logic [ADDR_W-1:0] r_rd_y;
    logic [2:0]        r_i;
    logic [4:0]        r_sb;

    logic              w_short;
    logic [4:0]        w_sb_limit;

    assign w_short = r_ws & (r_bt == 2'd2);

    // Short blocks only antialias the long-window subbands of a mixed block.
    always_comb begin
        w_sb_limit = SB_MAX;
        if (w_short)
            w_sb_limit = r_mixed ? 5'd1 : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ws      <= 1'b0;
            r_bt      <= 2'd0;
            r_mixed   <= 1'b0;
            r_wr_addr <= '0;
            r_base    <= '0;
            r_rd_x    <= '0;
            r_rd_y    <= '0;
            r_i       <= 3'd0;
            r_sb      <= 5'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (granule_start) begin
                        r_ws      <= window_switching_flag_in;
                        r_bt      <= block_type_in;
                        r_mixed   <= mixed_block_flag_in;
                        r_wr_addr <= '0;
                        r_state   <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (din_v) begin
                        if (r_wr_addr == LAST_LINE) begin
                            r_wr_addr <= '0;
                            if (w_sb_limit != 5'd0) begin
                                r_state <= S_BFLY;
                                r_sb    <= 5'd1;
                                r_i     <= 3'd0;
                                r_base  <= SB_STEP;
                                r_rd_x  <= SB_STEP - 1'b1;
                                r_rd_y  <= SB_STEP;
                            end else begin
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_wr_addr <= r_wr_addr + 1'b1;
                        end
                    end
                end
                S_BFLY: begin
                    if (pair_ready) begin
                        if (r_i == LAST_I) begin
                            r_i <= 3'd0;
                            if (r_sb == w_sb_limit) begin
                                r_state <= S_DONE;
                                r_sb    <= 5'd0;
                                r_base  <= '0;
                                r_rd_x  <= '0;
                                r_rd_y  <= '0;
                            end else begin
                                r_sb   <= r_sb + 1'b1;
                                r_base <= r_base + SB_STEP;
                                r_rd_x <= r_base + SB_STEP - 1'b1;
                                r_rd_y <= r_base + SB_STEP;
                            end
                        end else begin
                            r_i    <= r_i + 1'b1;
                            r_rd_x <= r_rd_x - 1'b1;
                            r_rd_y <= r_rd_y + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = (r_state == S_FILL);
    assign wr_en        = din_v & in_ready;
    assign wr_addr      = r_wr_addr;
    assign pair_v       = (r_state == S_BFLY);
    assign rd_addr_x    = r_rd_x;
    assign rd_addr_y    = r_rd_y;
    assign coef_idx     = r_i;
    assign busy         = (r_state != S_IDLE);
    assign granule_done = (r_state == S_DONE);

`ifdef ANTIALIAS_SCHED_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if ((granule_start & busy) |
                 (din_v & ~in_ready) |
                 (pair_ready & ~pair_v))
            r_err <= 1'b1;
    end

    assign proto_err = r_err;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_antialias_sched.sv
// Randomized bench for antialias_sched against a queue-based pair-schedule model.
// Tracks ANTIALIAS_SCHED_ERR_EN to predict proto_err.
module tb_antialias_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       granule_start;
    logic       ws;
    logic [1:0] bt;
    logic       mixed;
    logic       din_v;
    logic       in_ready;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic       pair_v;
    logic       pair_ready;
    logic [9:0] rd_addr_x;
    logic [9:0] rd_addr_y;
    logic [2:0] coef_idx;
    logic       busy;
    logic       granule_done;
    logic       proto_err;

    always #5 clk = ~clk;

    antialias_sched dut (
        .clk                      (clk),
        .rst                      (rst),
        .granule_start            (granule_start),
        .window_switching_flag_in (ws),
        .block_type_in            (bt),
        .mixed_block_flag_in      (mixed),
        .din_v                    (din_v),
        .in_ready                 (in_ready),
        .wr_en                    (wr_en),
        .wr_addr                  (wr_addr),
        .pair_v                   (pair_v),
        .pair_ready               (pair_ready),
        .rd_addr_x                (rd_addr_x),
        .rd_addr_y                (rd_addr_y),
        .coef_idx                 (coef_idx),
        .busy                     (busy),
        .granule_done             (granule_done),
        .proto_err                (proto_err)
    );

`ifdef ANTIALIAS_SCHED_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int P_IDLE = 0;
    localparam int P_FILL = 1;
    localparam int P_BFLY = 2;
    localparam int P_DONE = 3;

    int n_cmp = 0;
    int n_bad = 0;

    int ph = P_IDLE;
    int fcnt = 0;
    int qx[$];
    int qy[$];
    int qc[$];
    bit m_err = 1'b0;
    int pops = 0;
    int dones = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Expected pair list straight from the subband/butterfly definition.
    function automatic void build(input bit w, input logic [1:0] b,
                                  input bit m);
        int nsb;
        qx.delete();
        qy.delete();
        qc.delete();
        nsb = (w && b == 2'd2) ? (m ? 1 : 0) : 31;
        for (int sb = 1; sb <= nsb; sb++)
            for (int i = 0; i < 8; i++) begin
                qx.push_back(18 * sb - 1 - i);
                qy.push_back(18 * sb + i);
                qc.push_back(i);
            end
    endfunction

    function automatic void model_update();
        if (rst) begin
            ph = P_IDLE;
            fcnt = 0;
            qx.delete();
            qy.delete();
            qc.delete();
            m_err = 1'b0;
            return;
        end
        if (ERR_EN) begin
            if (granule_start && ph != P_IDLE) m_err = 1'b1;
            if (din_v && ph != P_FILL) m_err = 1'b1;
            if (pair_ready && ph != P_BFLY) m_err = 1'b1;
        end
        case (ph)
            P_IDLE: if (granule_start) begin
                build(ws, bt, mixed);
                fcnt = 0;
                ph = P_FILL;
            end
            P_FILL: if (din_v) begin
                if (fcnt == 575) begin
                    fcnt = 0;
                    ph = (qx.size() != 0) ? P_BFLY : P_DONE;
                end else begin
                    fcnt++;
                end
            end
            P_BFLY: if (pair_ready) begin
                void'(qx.pop_front());
                void'(qy.pop_front());
                void'(qc.pop_front());
                pops++;
                if (qx.size() == 0) ph = P_DONE;
            end
            default: ph = P_IDLE;
        endcase
    endfunction

    task automatic check_outputs();
        chk("in_ready", in_ready, ph == P_FILL);
        chk("wr_en", wr_en, din_v && ph == P_FILL);
        chk("wr_addr", wr_addr, fcnt);
        chk("pair_v", pair_v, ph == P_BFLY);
        if (ph == P_BFLY && qx.size() != 0) begin
            chk("rd_addr_x", rd_addr_x, qx[0]);
            chk("rd_addr_y", rd_addr_y, qy[0]);
            chk("coef_idx", coef_idx, qc[0]);
        end
        chk("busy", busy, ph != P_IDLE);
        chk("granule_done", granule_done, ph == P_DONE);
        chk("proto_err", proto_err, m_err);
        if (granule_done) dones++;
    endtask

    task automatic cyc();
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic chk_zero();
        chk("rst_x", rd_addr_x, 0);
        chk("rst_y", rd_addr_y, 0);
        chk("rst_coef", coef_idx, 0);
        chk("rst_waddr", wr_addr, 0);
        chk("rst_done", granule_done, 0);
    endtask

    task automatic run_granule(input bit w, input logic [1:0] b,
                               input bit m, input int dpct, input int rpct,
                               input int stall_pair, input int rst_pair,
                               input int exp_pairs);
        int  limit;
        int  hold;
        bit  did_rst;
        limit = 0;
        hold = 0;
        did_rst = 1'b0;
        pops = 0;
        dones = 0;
        granule_start = 1'b1;
        ws = w;
        bt = b;
        mixed = m;
        din_v = 1'b0;
        pair_ready = 1'b0;
        cyc();
        granule_start = 1'b0;
        while (ph != P_IDLE && limit < 5000) begin
            din_v = ($urandom_range(99) < dpct);
            pair_ready = ($urandom_range(99) < rpct);
            granule_start = ($urandom_range(199) == 0);
            ws = 1'($urandom);
            bt = 2'($urandom);
            mixed = 1'($urandom);
            if (ph == P_BFLY && pops == stall_pair && hold < 3) begin
                pair_ready = 1'b0;
                hold++;
            end
            if (ph == P_BFLY && pops == rst_pair) begin
                rst = 1'b1;
                din_v = 1'b0;
                pair_ready = 1'b0;
                granule_start = 1'b0;
                cyc();
                rst = 1'b0;
                chk_zero();
                did_rst = 1'b1;
            end else begin
                cyc();
            end
            limit++;
        end
        if (limit >= 5000) chk("timeout", 1, 0);
        if (did_rst) begin
            chk("no_done_after_rst", dones, 0);
        end else begin
            chk("pair_count", pops, exp_pairs);
            chk("done_count", dones, 1);
        end
        granule_start = 1'b0;
        din_v = 1'b0;
        pair_ready = 1'b0;
        cyc();
    endtask

    initial begin
        bit         w;
        logic [1:0] b;
        bit         m;
        rst = 1'b1;
        granule_start = 1'b0;
        ws = 1'b0;
        bt = 2'd0;
        mixed = 1'b0;
        din_v = 1'b0;
        pair_ready = 1'b0;
        @(negedge clk);
        cyc();
        cyc();
        chk_zero();
        rst = 1'b0;
        cyc();

        run_granule(1'b0, 2'd0, 1'b0, 100, 100, -1, -1, 248);
        run_granule(1'b1, 2'd2, 1'b0, 100, 100, -1, -1, 0);
        run_granule(1'b1, 2'd2, 1'b1, 100, 100, -1, -1, 8);
        run_granule(1'b0, 2'd0, 1'b0, 80, 100, 4, -1, 248);
        run_granule(1'b0, 2'd0, 1'b0, 100, 100, -1, 100, 0);
        run_granule(1'b0, 2'd0, 1'b0, 100, 100, -1, -1, 248);

        for (int k = 0; k < 6; k++) begin
            w = 1'($urandom);
            b = 2'($urandom);
            m = 1'($urandom);
            if (k < 2) begin
                w = 1'b1;
                b = 2'd2;
            end
            run_granule(w, b, m, 60 + $urandom_range(40),
                        30 + $urandom_range(70), -1, -1,
                        (w && b == 2'd2) ? (m ? 8 : 0) : 248);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
